// File: rtl/drm_activator_multi_bfm.sv
// -----------------------------------------------------------------------------
// drm_activator_multi_bfm
// Multi-channel simulation model of DRM activators. It replaces the
// single-activator switch with NUM_CH independent channels. Each channel has
// three parts:
//   - a license unlock handshake with a fixed unlock latency,
//   - a timed license that expires after a number of prescaled ticks,
//   - a saturating usage meter that can be read over a request/response port.
//
// Ports:
//   drm_aclk      clock
//   drm_arstn     asynchronous active-low reset
//   lic_valid     license command valid
//   lic_ready     license command accepted when lic_valid & lic_ready
//   lic_chan      target channel of the license command
//   lic_revoke    1 = revoke the channel, 0 = load lic_duration
//   lic_duration  license length in timer ticks
//   usage_pulse   one usage event per set bit per cycle
//   activated     per-channel ACTIVE status (registered)
//   expired       per-channel EXPIRED status (registered)
//   rd_req        meter read request, single-cycle pulse
//   rd_chan       channel to read
//   rd_valid      read response valid, one cycle after rd_req
//   rd_data       meter value of the read channel (holds when rd_valid=0)
//   rd_sat        saturation flag of the read channel
//
// Optional feature macro: DRM_METER_CLEAR_ON_READ_EN
//   defined   - an accepted read clears that channel's meter and sat flag
//   undefined - reads are non-destructive
// -----------------------------------------------------------------------------
module drm_activator_multi_bfm #(
   parameter int NUM_CH     = 4,
   parameter int CH_W       = 2,
   parameter int TIMER_W    = 16,
   parameter int METER_W    = 32,
   parameter int UNLOCK_LAT = 8,
   parameter int TICK_DIV   = 4
) (
   input  logic               drm_aclk,
   input  logic               drm_arstn,
   input  logic               lic_valid,
   output logic               lic_ready,
   input  logic [CH_W-1:0]    lic_chan,
   input  logic               lic_revoke,
   input  logic [TIMER_W-1:0] lic_duration,
   input  logic [NUM_CH-1:0]  usage_pulse,
   output logic [NUM_CH-1:0]  activated,
   output logic [NUM_CH-1:0]  expired,
   input  logic               rd_req,
   input  logic [CH_W-1:0]    rd_chan,
   output logic               rd_valid,
   output logic [METER_W-1:0] rd_data,
   output logic               rd_sat
);

   localparam int                 PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int                 LAT_W     = $clog2(UNLOCK_LAT + 1);
   localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(TICK_DIV - 1);
   localparam logic [LAT_W-1:0]   LAT_INIT  = LAT_W'(UNLOCK_LAT);
   localparam logic [METER_W-1:0] METER_MAX = {METER_W{1'b1}};

   typedef enum logic [1:0] {
      ST_LOCKED    = 2'd0,
      ST_UNLOCKING = 2'd1,
      ST_ACTIVE    = 2'd2,
      ST_EXPIRED   = 2'd3
   } ch_state_t;

   ch_state_t          state_r      [NUM_CH];
   ch_state_t          state_nx_s   [NUM_CH];
   logic [LAT_W-1:0]   lat_cnt_r    [NUM_CH];
   logic [LAT_W-1:0]   lat_cnt_nx_s [NUM_CH];
   logic [TIMER_W-1:0] timer_r      [NUM_CH];
   logic [TIMER_W-1:0] timer_nx_s   [NUM_CH];
   logic [METER_W-1:0] meter_r      [NUM_CH];
   logic [METER_W-1:0] meter_nx_s   [NUM_CH];
   logic [NUM_CH-1:0]  sat_r;
   logic [NUM_CH-1:0]  sat_nx_s;

   logic [PRE_W-1:0]   presc_r;
   logic               tick_s;
   logic               lic_acc_s;
   logic [NUM_CH-1:0]  load_s;
   logic [NUM_CH-1:0]  revoke_s;
   logic [NUM_CH-1:0]  rd_hit_s;
   logic [NUM_CH-1:0]  inc_s;
   logic [METER_W-1:0] rd_data_sel_s;
   logic               rd_sat_sel_s;

   logic               lic_ready_r;
   logic [NUM_CH-1:0]  activated_r;
   logic [NUM_CH-1:0]  expired_r;
   logic               rd_valid_r;
   logic [METER_W-1:0] rd_data_r;
   logic               rd_sat_r;

   assign lic_ready = lic_ready_r;
   assign activated = activated_r;
   assign expired   = expired_r;
   assign rd_valid  = rd_valid_r;
   assign rd_data   = rd_data_r;
   assign rd_sat    = rd_sat_r;

   // The tick fires in the cycle in which the prescaler wraps back to 0.
   assign tick_s    = (presc_r == PRE_MAX);
   assign lic_acc_s = lic_valid & lic_ready_r;

   // Command decode; an out-of-range channel matches no bit, so it is dropped.
   always_comb begin
      load_s   = {NUM_CH{1'b0}};
      revoke_s = {NUM_CH{1'b0}};
      rd_hit_s = {NUM_CH{1'b0}};
      inc_s    = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         if (lic_acc_s && (lic_chan == CH_W'(i))) begin
            revoke_s[i] = lic_revoke;
            load_s[i]   = ~lic_revoke & (lic_duration != {TIMER_W{1'b0}});
         end else begin
            revoke_s[i] = 1'b0;
            load_s[i]   = 1'b0;
         end
         rd_hit_s[i] = rd_req & (rd_chan == CH_W'(i));
         inc_s[i]    = usage_pulse[i] & (state_r[i] == ST_ACTIVE);
      end
   end

   // Per-channel license FSM: next state, unlock counter and license timer.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_nx_s[i]   = state_r[i];
         lat_cnt_nx_s[i] = lat_cnt_r[i];
         timer_nx_s[i]   = timer_r[i];
         if (revoke_s[i]) begin
            state_nx_s[i]   = ST_LOCKED;
            lat_cnt_nx_s[i] = {LAT_W{1'b0}};
            timer_nx_s[i]   = {TIMER_W{1'b0}};
         end else begin
            case (state_r[i])
               ST_LOCKED, ST_EXPIRED: begin
                  if (load_s[i]) begin
                     state_nx_s[i]   = ST_UNLOCKING;
                     lat_cnt_nx_s[i] = LAT_INIT;
                     timer_nx_s[i]   = lic_duration;
                  end else begin
                     state_nx_s[i] = state_r[i];
                  end
               end
               ST_UNLOCKING: begin
                  if (lat_cnt_r[i] <= LAT_W'(1'b1)) begin
                     state_nx_s[i]   = ST_ACTIVE;
                     lat_cnt_nx_s[i] = {LAT_W{1'b0}};
                  end else begin
                     lat_cnt_nx_s[i] = lat_cnt_r[i] - LAT_W'(1'b1);
                  end
               end
               ST_ACTIVE: begin
                  // A reload beats a coincident tick: no decrement that cycle.
                  if (load_s[i]) begin
                     timer_nx_s[i] = lic_duration;
                  end else if (tick_s) begin
                     if (timer_r[i] <= TIMER_W'(1'b1)) begin
                        state_nx_s[i] = ST_EXPIRED;
                        timer_nx_s[i] = {TIMER_W{1'b0}};
                     end else begin
                        timer_nx_s[i] = timer_r[i] - TIMER_W'(1'b1);
                     end
                  end else begin
                     timer_nx_s[i] = timer_r[i];
                  end
               end
               default: begin
                  state_nx_s[i] = ST_LOCKED;
               end
            endcase
         end
      end
   end

   // Saturating usage meters; the sticky sat flag sets when the meter reaches all-ones.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         meter_nx_s[i] = meter_r[i];
         sat_nx_s[i]   = sat_r[i];
`ifdef DRM_METER_CLEAR_ON_READ_EN
         if (rd_hit_s[i]) begin
            meter_nx_s[i] = inc_s[i] ? METER_W'(1'b1) : {METER_W{1'b0}};
            sat_nx_s[i]   = 1'b0;
         end else
`endif
         if (inc_s[i]) begin
            if (meter_r[i] == METER_MAX) begin
               meter_nx_s[i] = meter_r[i];
               sat_nx_s[i]   = 1'b1;
            end else begin
               meter_nx_s[i] = meter_r[i] + METER_W'(1'b1);
               sat_nx_s[i]   = sat_r[i] | (meter_r[i] == (METER_MAX - METER_W'(1'b1)));
            end
         end else begin
            meter_nx_s[i] = meter_r[i];
         end
      end
   end

   // Read mux on the pre-update meter value; no hit (out-of-range channel) returns 0/0.
   always_comb begin
      rd_data_sel_s = {METER_W{1'b0}};
      rd_sat_sel_s  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_hit_s[i]) begin
            rd_data_sel_s = meter_r[i];
            rd_sat_sel_s  = sat_r[i];
         end else begin
            rd_data_sel_s = rd_data_sel_s;
         end
      end
   end

   // Prescaler and per-channel state registers.
   always_ff @(posedge drm_aclk or negedge drm_arstn) begin
      if (!drm_arstn) begin
         presc_r <= {PRE_W{1'b0}};
         sat_r   <= {NUM_CH{1'b0}};
         for (int i = 0; i < NUM_CH; i++) begin
            state_r[i]   <= ST_LOCKED;
            lat_cnt_r[i] <= {LAT_W{1'b0}};
            timer_r[i]   <= {TIMER_W{1'b0}};
            meter_r[i]   <= {METER_W{1'b0}};
         end
      end else begin
         presc_r <= tick_s ? {PRE_W{1'b0}} : (presc_r + PRE_W'(1'b1));
         sat_r   <= sat_nx_s;
         for (int i = 0; i < NUM_CH; i++) begin
            state_r[i]   <= state_nx_s[i];
            lat_cnt_r[i] <= lat_cnt_nx_s[i];
            timer_r[i]   <= timer_nx_s[i];
            meter_r[i]   <= meter_nx_s[i];
         end
      end
   end

   // Registered status and handshake outputs.
   always_ff @(posedge drm_aclk or negedge drm_arstn) begin
      if (!drm_arstn) begin
         lic_ready_r <= 1'b0;
         activated_r <= {NUM_CH{1'b0}};
         expired_r   <= {NUM_CH{1'b0}};
         rd_valid_r  <= 1'b0;
         rd_data_r   <= {METER_W{1'b0}};
         rd_sat_r    <= 1'b0;
      end else begin
         // Ready drops for exactly one cycle after every accepted command.
         lic_ready_r <= ~lic_acc_s;
         for (int i = 0; i < NUM_CH; i++) begin
            activated_r[i] <= (state_nx_s[i] == ST_ACTIVE);
            expired_r[i]   <= (state_nx_s[i] == ST_EXPIRED);
         end
         rd_valid_r <= rd_req;
         if (rd_req) begin
            rd_data_r <= rd_data_sel_s;
            rd_sat_r  <= rd_sat_sel_s;
         end else begin
            rd_data_r <= rd_data_r;
            rd_sat_r  <= rd_sat_r;
         end
      end
   end

endmodule

// File: tb/tb_drm_activator_multi_bfm.sv
// -----------------------------------------------------------------------------
// tb_drm_activator_multi_bfm
// Self-checking bench for drm_activator_multi_bfm. It runs in two parts:
//   - a cycle table drives the first license flow and checks every output,
//   - hand-written sequences cover reload-vs-tick, revoke, saturation,
//     read/usage collisions and reset mid-operation.
// The DUT is built with five channels (so 3-bit channel ids reach past
// NUM_CH) and a 4-bit meter.
// -----------------------------------------------------------------------------
module tb_drm_activator_multi_bfm;

   localparam int NUM_CH     = 5;
   localparam int CH_W       = 3;
   localparam int TIMER_W    = 16;
   localparam int METER_W    = 4;
   localparam int UNLOCK_LAT = 8;
   localparam int TICK_DIV   = 4;

`ifdef DRM_METER_CLEAR_ON_READ_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               lic_valid;
   logic               lic_ready;
   logic [CH_W-1:0]    lic_chan;
   logic               lic_revoke;
   logic [TIMER_W-1:0] lic_duration;
   logic [NUM_CH-1:0]  usage_pulse;
   logic [NUM_CH-1:0]  activated;
   logic [NUM_CH-1:0]  expired;
   logic               rd_req;
   logic [CH_W-1:0]    rd_chan;
   logic               rd_valid;
   logic [METER_W-1:0] rd_data;
   logic               rd_sat;

   drm_activator_multi_bfm #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .TIMER_W(TIMER_W), .METER_W(METER_W),
      .UNLOCK_LAT(UNLOCK_LAT), .TICK_DIV(TICK_DIV)
   ) dut (
      .drm_aclk(clk), .drm_arstn(rst_n),
      .lic_valid(lic_valid), .lic_ready(lic_ready), .lic_chan(lic_chan),
      .lic_revoke(lic_revoke), .lic_duration(lic_duration),
      .usage_pulse(usage_pulse), .activated(activated), .expired(expired),
      .rd_req(rd_req), .rd_chan(rd_chan), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_sat(rd_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [2:0]  ch;
      logic [15:0] dur;
      logic [4:0]  usage;
      logic        rr;
      logic [2:0]  rch;
      logic        e_rdy;
      logic [4:0]  e_act;
      logic [4:0]  e_exp;
      logic        e_rdv;
      logic [3:0]  e_rdd;
      logic        e_sat;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   edge_cnt = 0;

   function automatic vec_t mk(input logic v, input logic [2:0] ch, input logic [15:0] dur,
                               input logic [4:0] usage, input logic rr, input logic [2:0] rch,
                               input logic e_rdy, input logic [4:0] e_act, input logic [4:0] e_exp,
                               input logic e_rdv, input logic [3:0] e_rdd, input logic e_sat);
      vec_t r;
      r.v = v; r.ch = ch; r.dur = dur; r.usage = usage; r.rr = rr; r.rch = rch;
      r.e_rdy = e_rdy; r.e_act = e_act; r.e_exp = e_exp;
      r.e_rdv = e_rdv; r.e_rdd = e_rdd; r.e_sat = e_sat;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_cnt++;
   endtask

   task automatic idle();
      lic_valid    = 1'b0;
      lic_chan     = 3'd0;
      lic_revoke   = 1'b0;
      lic_duration = 16'd0;
      usage_pulse  = 5'b00000;
      rd_req       = 1'b0;
      rd_chan      = 3'd0;
   endtask

   // One license command, issued while ready is known to be high.
   task automatic cmd(input logic [2:0] ch, input logic [15:0] dur, input logic rev);
      check("lic_ready_before_cmd", lic_ready, 1'b1);
      lic_valid    = 1'b1;
      lic_chan     = ch;
      lic_duration = dur;
      lic_revoke   = rev;
      step();
      lic_valid    = 1'b0;
      lic_revoke   = 1'b0;
      lic_duration = 16'd0;
   endtask

   task automatic pulses(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         usage_pulse     = 5'b00000;
         usage_pulse[ch] = 1'b1;
         step();
      end
      usage_pulse = 5'b00000;
   endtask

   task automatic read_chk(input string name, input logic [2:0] ch,
                           input logic [3:0] e_d, input logic e_s);
      rd_req  = 1'b1;
      rd_chan = ch;
      step();
      rd_req  = 1'b0;
      check({name, "_rd_valid"}, rd_valid, 1'b1);
      check({name, "_rd_data"}, rd_data, e_d);
      check({name, "_rd_sat"}, rd_sat, e_s);
   endtask

   // Position so that the next edge is a timer tick (prescaler at TICK_DIV-1).
   task automatic tick_edge_next();
      while (((edge_cnt + 1) % TICK_DIV) != 0) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle();
      // Edge E(k) is the k-th posedge after reset release; rows start at E2.
      tbl.push_back(mk(1'b1, 3'd0, 16'd3, 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b1, 3'd1, 16'd5, 5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b1, 3'd6, 16'd5, 5'b00010, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b1, 3'd4, 16'd0, 5'b00000, 1'b0, 3'd0, 1'b0, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b1, 3'd1, 1'b1, 5'b00000, 5'b00000, 1'b1, 4'd0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00001, 1'b0, 3'd0, 1'b1, 5'b00001, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00001, 1'b0, 3'd0, 1'b1, 5'b00001, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b1, 3'd0, 1'b1, 5'b00001, 5'b00000, 1'b1, 4'd1, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b0, 3'd0, 1'b1, 5'b00001, 5'b00000, 1'b0, 4'd1, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b1, 3'd7, 1'b1, 5'b00001, 5'b00000, 1'b1, 4'd0, 1'b0));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b0, 3'd0, 1'b1, 5'b00001, 5'b00000, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00001, 1'b0, 4'd0, 1'b0));
      tbl.push_back(mk(1'b0, 3'd0, 16'd0, 5'b00000, 1'b0, 3'd0, 1'b1, 5'b00000, 5'b00001, 1'b0, 4'd0, 1'b0));

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_lic_ready", lic_ready, 1'b0);
      check("rst_activated", activated, 5'b00000);
      check("rst_expired", expired, 5'b00000);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", rd_data, 4'd0);
      check("rst_rd_sat", rd_sat, 1'b0);
      rst_n    = 1'b1;
      edge_cnt = 0;
      check("rel_lic_ready_low", lic_ready, 1'b0);
      step();
      check("rel_lic_ready_high", lic_ready, 1'b1);

      // Table: ch0 duration 3, rejected/dropped/zero-length commands, reads.
      for (int r = 0; r < tbl.size(); r++) begin
         lic_valid    = tbl[r].v;
         lic_chan     = tbl[r].ch;
         lic_duration = tbl[r].dur;
         usage_pulse  = tbl[r].usage;
         rd_req       = tbl[r].rr;
         rd_chan      = tbl[r].rch;
         step();
         check($sformatf("row%0d_lic_ready", r), lic_ready, tbl[r].e_rdy);
         check($sformatf("row%0d_activated", r), activated, tbl[r].e_act);
         check($sformatf("row%0d_expired", r), expired, tbl[r].e_exp);
         check($sformatf("row%0d_rd_valid", r), rd_valid, tbl[r].e_rdv);
         check($sformatf("row%0d_rd_data", r), rd_data, tbl[r].e_rdd);
         check($sformatf("row%0d_rd_sat", r), rd_sat, tbl[r].e_sat);
      end
      idle();

      // ch1: reload on the tick that would have expired it.
      cmd(3'd1, 16'd2, 1'b0);
      repeat (7) step();
      check("ch1_unlock_lat_minus1", activated[1], 1'b0);
      step();
      check("ch1_unlock_lat", activated[1], 1'b1);
      tick_edge_next();
      step();
      check("ch1_after_first_tick", activated[1], 1'b1);
      tick_edge_next();
      cmd(3'd1, 16'd10, 1'b0);
      check("ch1_reload_no_expiry_act", activated[1], 1'b1);
      check("ch1_reload_no_expiry_exp", expired[1], 1'b0);
      for (int t = 1; t <= 9; t++) begin
         tick_edge_next();
         step();
         check($sformatf("ch1_active_tick%0d", t), activated[1], 1'b1);
      end
      tick_edge_next();
      step();
      check("ch1_expired_tick10", expired[1], 1'b1);
      check("ch1_inactive_tick10", activated[1], 1'b0);

      // ch2: 5 pulses while ACTIVE, revoke, 2 dropped pulses.
      cmd(3'd2, 16'd1000, 1'b0);
      repeat (8) step();
      check("ch2_active", activated[2], 1'b1);
      pulses(2, 5);
      cmd(3'd2, 16'd0, 1'b1);
      check("ch2_revoked", activated[2], 1'b0);
      check("ch2_revoke_ready_low", lic_ready, 1'b0);
      pulses(2, 2);
      read_chk("ch2", 3'd2, 4'd5, 1'b0);

      // ch3: saturation at 15 with sticky flag.
      cmd(3'd3, 16'd1000, 1'b0);
      repeat (8) step();
      check("ch3_active", activated[3], 1'b1);
      pulses(3, 20);
      read_chk("ch3_sat", 3'd3, 4'd15, 1'b1);
      step();
      check("ch3_idle_rd_valid", rd_valid, 1'b0);
      check("ch3_rd_data_hold", rd_data, 4'd15);
      read_chk("ch3_second", 3'd3, CLR ? 4'd0 : 4'd15, CLR ? 1'b0 : 1'b1);

      // ch0: read collides with a usage pulse, then a back-to-back read.
      cmd(3'd0, 16'd1000, 1'b0);
      repeat (8) step();
      check("ch0_reactivated", activated[0], 1'b1);
      check("ch0_not_expired", expired[0], 1'b0);
      pulses(0, CLR ? 7 : 6);
      rd_req         = 1'b1;
      rd_chan        = 3'd0;
      usage_pulse[0] = 1'b1;
      step();
      usage_pulse = 5'b00000;
      check("ch0_coll_rd_valid", rd_valid, 1'b1);
      check("ch0_coll_rd_data", rd_data, 4'd7);
      step();
      rd_req = 1'b0;
      check("ch0_b2b_rd_valid", rd_valid, 1'b1);
      check("ch0_b2b_rd_data", rd_data, CLR ? 4'd1 : 4'd8);

      // Reset while ch1 is unlocking and a read is pending.
      cmd(3'd1, 16'd5, 1'b0);
      step();
      rd_req  = 1'b1;
      rd_chan = 3'd3;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_lic_ready", lic_ready, 1'b0);
      check("mid_rst_activated", activated, 5'b00000);
      check("mid_rst_expired", expired, 5'b00000);
      check("mid_rst_rd_valid", rd_valid, 1'b0);
      check("mid_rst_rd_data", rd_data, 4'd0);
      check("mid_rst_rd_sat", rd_sat, 1'b0);
      @(posedge clk);
      #1;
      check("mid_rst_no_rd_valid", rd_valid, 1'b0);
      rd_req = 1'b0;
      #2;
      rst_n    = 1'b1;
      edge_cnt = 0;
      check("mid_rel_ready_low", lic_ready, 1'b0);
      step();
      check("mid_rel_ready_high", lic_ready, 1'b1);
      repeat (10) step();
      check("mid_rel_unlock_aborted", activated, 5'b00000);
      read_chk("mid_rel_meter_cleared", 3'd3, 4'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/drm_activator_multi_bfm.md
Name: drm_activator_multi_bfm

Overview:
- Parametrised, multi-channel simulation model of DRM activators.
- Replaces the single-activator BFM switch with NUM_CH independent channels. Each channel has:
  - a license unlock handshake with unlock latency,
  - a timed license that expires,
  - a saturating usage meter readable over a request/response port.
- Sits where the activator instance sits in sim builds. Drives the activation status seen by user logic, so licensed, expired and revoked flows can be exercised without a live Controller.

Parameters:
- NUM_CH, 4, number of activator channels (1..16).
- CH_W, 2, channel index width; must hold NUM_CH-1, minimum 1.
- TIMER_W, 16, license duration width, in ticks.
- METER_W, 32, usage meter width per channel.
- UNLOCK_LAT, 8, cycles from license accept to activation (>=1).
- TICK_DIV, 4, clock cycles per license-timer tick (>=1).

Ports:
- drm_aclk  in  1  clock.
- drm_arstn  in  1  asynchronous active-low reset.
- lic_valid  in  1  license command valid.
- lic_ready  out  1  license command accepted when valid&ready.
- lic_chan  in  CH_W  target channel.
- lic_revoke  in  1  1 = revoke, 0 = load duration.
- lic_duration  in  TIMER_W  license length in ticks.
- usage_pulse  in  NUM_CH  one usage event per set bit per cycle.
- activated  out  NUM_CH  channel in ACTIVE state.
- expired  out  NUM_CH  channel in EXPIRED state.
- rd_req  in  1  meter read request, single-cycle pulse.
- rd_chan  in  CH_W  channel to read.
- rd_valid  out  1  read response valid.
- rd_data  out  METER_W  meter value.
- rd_sat  out  1  meter saturated flag of read channel.

Behaviour:
- Reset (drm_arstn=0, async assert, sync deassert on drm_aclk):
  - all channels LOCKED; timers, meters and sat flags 0;
  - prescaler 0;
  - lic_ready=0, activated=0, expired=0, rd_valid=0, rd_data=0, rd_sat=0.
  - Reset mid-operation aborts every state immediately.
- lic_ready rises 1 cycle after reset release.
  - After each accepted command it is 0 for exactly 1 cycle, so at most one command per 2 cycles.
  - lic_valid with lic_chan >= NUM_CH: command accepted and dropped.
- Prescaler: free-running 0..TICK_DIV-1. A tick is issued in the cycle the prescaler wraps to 0.
- Per-channel FSM:
  - LOCKED:
    - load with duration>0 -> UNLOCKING; unlock counter = UNLOCK_LAT, timer = duration.
    - duration==0 -> ignored.
  - UNLOCKING: counter decrements each cycle; at 1 -> ACTIVE. activated rises UNLOCK_LAT cycles after the accept edge.
  - ACTIVE:
    - timer decrements on each tick; on a tick with timer==1 -> EXPIRED.
    - load with duration>0: timer reloaded, stays ACTIVE, no unlock latency.
    - load with duration==0: ignored.
  - EXPIRED: load with duration>0 -> UNLOCKING.
  - Any state: revoke -> LOCKED next cycle; timer cleared; meter and sat retained.
  - Load and tick in the same cycle: load wins, no decrement.
- Meter:
  - increments by 1 per cycle in which usage_pulse[i]=1 and channel i is ACTIVE; otherwise the pulse is dropped.
  - saturates at all-ones; sat flag sets sticky at saturation.
- Read:
  - rd_req sampled at edge N; rd_valid=1 for one cycle at N+1 with rd_data/rd_sat of rd_chan.
  - rd_chan >= NUM_CH returns 0/0.
  - A same-cycle usage pulse on the read channel is not included (pre-increment value returned).
  - Back-to-back rd_req: one response per request, in order.
  - rd_data holds its last value when rd_valid=0.
- Status outputs are registered, with no combinational path from inputs.

Optional Feature:
- Macro DRM_METER_CLEAR_ON_READ_EN.
- Defined: an accepted read clears the meter and sat flag of that channel in the same cycle it samples them. A usage pulse coincident with the read leaves the meter at 1.
- Undefined: reads are non-destructive; meters only clear on reset.

Test Plan:
- Reset then load ch0 duration=3, UNLOCK_LAT=8, TICK_DIV=4 -> activated[0]=1 exactly 8 cycles after accept, then expired[0]=1 after 3 ticks; other channels stay 0.
- ch1 ACTIVE, reload duration=10 when timer=1 coincident with a tick -> no expiry; activated[1] stays 1 for 10 more ticks.
- ch2 ACTIVE, 5 usage pulses then 2 pulses while LOCKED after revoke -> read ch2 returns rd_data=5, rd_sat=0; activated[2]=0 the cycle after revoke.
- METER_W=4, 20 pulses on ch3 while ACTIVE -> rd_data=15, rd_sat=1. With DRM_METER_CLEAR_ON_READ_EN, a second read returns 0/0.
- Read ch0 with simultaneous usage pulse on ch0 (meter=7) -> rd_data=7. Next read gives 8; with the macro it gives 1.
- drm_arstn pulsed low while ch1 UNLOCKING and rd_req pending -> all outputs 0 immediately; no rd_valid emitted; lic_ready returns 1 cycle after release.
